// File: rtl/mac_feeder_pkg.sv
// mac_feeder_pkg
//   Shared definitions for the mac_feeder slice:
//   - state_t: feeder FSM states
//   - ERR_*:   bit positions inside the sticky err vector
//   - DATA_W:  width of the IEEE-754 double words carried unchanged to mac
package mac_feeder_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    DRAIN    = 2'd2,
    EOF_WAIT = 2'd3
  } state_t;

  localparam int ERR_ORDER = 0;
  localparam int ERR_XWR   = 1;
  localparam int ERR_COL   = 2;

  localparam int DATA_W = 64;

endpackage

// File: rtl/mac_feeder_xbuf.sv
// mac_feeder_xbuf
//   Simple dual-port x-vector buffer: one write port, one synchronous read
//   port, no reset (contents are undefined after power-up or reset).
// Ports:
//   clk            clock
//   we/waddr/wdata write port
//   re/raddr       read request; rdata is registered and holds when re is low
//   rdata          read data, valid the cycle after re
module mac_feeder_xbuf
  import mac_feeder_pkg::*;
#(
  parameter int X_DEPTH      = 1024,
  parameter int LOG2_X_DEPTH = $clog2(X_DEPTH)
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [LOG2_X_DEPTH-1:0] waddr,
  input  logic [DATA_W-1:0]       wdata,
  input  logic                    re,
  input  logic [LOG2_X_DEPTH-1:0] raddr,
  output logic [DATA_W-1:0]       rdata
);

  logic [DATA_W-1:0] mem [X_DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/mac_feeder.sv
// mac_feeder
//   Feeds the SpMV mac block. Holds the dense x-vector, accepts a stream of
//   nonzeros (row, col, value) and issues one mac write beat per nonzero with
//   v0 = value and v1 = x[col]. After the last nonzero drains out of the
//   two-stage pipeline it waits EOF_GAP cycles and pulses mac_eof/done.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   start                    begin a matrix (IDLE only)
//   x_wr/x_addr/x_data       x-buffer load (IDLE only; otherwise flagged)
//   nz_valid/nz_ready        nonzero handshake; nz_ready depends on state only
//   nz_row/nz_col/nz_val     nonzero fields, nz_last marks the final one
//   mac_wr/row/v0/v1/eof     registered beat to mac (eof decoded from state)
//   busy                     state != IDLE
//   done                     one-cycle pulse together with mac_eof
//   err                      sticky flags {col out of range, x_wr busy, row order}
//   nnz_count                nonzeros accepted in the current or last run
module mac_feeder
  import mac_feeder_pkg::*;
#(
  parameter int INTERMEDIATOR_DEPTH      = 8,
  parameter int LOG2_INTERMEDIATOR_DEPTH = $clog2(INTERMEDIATOR_DEPTH),
  parameter int X_DEPTH                  = 1024,
  parameter int LOG2_X_DEPTH             = $clog2(X_DEPTH),
  parameter int EOF_GAP                  = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic                                x_wr,
  input  logic [LOG2_X_DEPTH-1:0]             x_addr,
  input  logic [DATA_W-1:0]                   x_data,
  input  logic                                nz_valid,
  output logic                                nz_ready,
  input  logic [31:0]                         nz_row,
  input  logic [31:0]                         nz_col,
  input  logic [DATA_W-1:0]                   nz_val,
  input  logic                                nz_last,
  output logic                                mac_wr,
  output logic [LOG2_INTERMEDIATOR_DEPTH-1:0] mac_row,
  output logic [DATA_W-1:0]                   mac_v0,
  output logic [DATA_W-1:0]                   mac_v1,
  output logic                                mac_eof,
  output logic                                busy,
  output logic                                done,
  output logic [2:0]                          err,
  output logic [31:0]                         nnz_count
);

  localparam int GAP_W = $clog2(EOF_GAP + 1);

  state_t state_q, state_d;

  logic             accept;
  logic             col_oob;
  logic             start_run;
  logic [GAP_W-1:0] gap_q;
  logic [31:0]      last_row_q;
  logic [DATA_W-1:0] x_rdata;

  logic                                vld_p0;
  logic [LOG2_INTERMEDIATOR_DEPTH-1:0] row_p0;
  logic [DATA_W-1:0]                   val_p0;

  logic                                vld_p1;
  logic [LOG2_INTERMEDIATOR_DEPTH-1:0] row_p1;
  logic [DATA_W-1:0]                   val_p1;
  logic [DATA_W-1:0]                   x_p1;

  assign nz_ready  = (state_q == RUN);
  assign accept    = nz_valid && nz_ready;
  assign start_run = (state_q == IDLE) && start;
  assign busy      = (state_q != IDLE);
  assign mac_eof   = (state_q == EOF_WAIT) && (gap_q == '0);
  assign done      = mac_eof;

  // Upper column bits must be zero; otherwise the address wraps into the buffer.
  assign col_oob = (nz_col >> LOG2_X_DEPTH) != 32'd0;

  mac_feeder_xbuf #(
    .X_DEPTH      (X_DEPTH),
    .LOG2_X_DEPTH (LOG2_X_DEPTH)
  ) u_xbuf (
    .clk   (clk),
    .we    (x_wr && (state_q == IDLE)),
    .waddr (x_addr),
    .wdata (x_data),
    .re    (accept),
    .raddr (nz_col[LOG2_X_DEPTH-1:0]),
    .rdata (x_rdata)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (start) state_d = RUN;
      RUN:      if (accept && nz_last) state_d = DRAIN;
      DRAIN:    if (!vld_p0 && !vld_p1) state_d = EOF_WAIT;
      EOF_WAIT: if (gap_q == '0) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      gap_q      <= '0;
      last_row_q <= '0;
      err        <= '0;
      nnz_count  <= '0;
    end else begin
      state_q <= state_d;

      if (state_q == DRAIN && state_d == EOF_WAIT)
        gap_q <= GAP_W'(EOF_GAP - 1);
      else if (state_q == EOF_WAIT && gap_q != '0)
        gap_q <= gap_q - 1'b1;

      if (start_run) begin
        err        <= '0;
        nnz_count  <= '0;
        last_row_q <= '0;
      end else begin
        if (accept) begin
          nnz_count  <= nnz_count + 32'd1;
          last_row_q <= nz_row;
          if (nz_row < last_row_q) err[ERR_ORDER] <= 1'b1;
          if (col_oob)             err[ERR_COL]   <= 1'b1;
        end
        if (x_wr && state_q != IDLE) err[ERR_XWR] <= 1'b1;
      end
    end
  end

  // Stage p0: nonzero captured on accept, x-buffer read in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_p0 <= 1'b0;
    else     vld_p0 <= accept;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      row_p0 <= nz_row[LOG2_INTERMEDIATOR_DEPTH-1:0];
      val_p0 <= nz_val;
    end
  end

  // Stage p1: x[col] joins the nonzero value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_p1 <= 1'b0;
    else     vld_p1 <= vld_p0;
  end

  always_ff @(posedge clk) begin
    if (vld_p0) begin
      row_p1 <= row_p0;
      val_p1 <= val_p0;
      x_p1   <= x_rdata;
    end
  end

  // Output stage: registered beat to mac; data holds while mac_wr is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mac_wr  <= 1'b0;
      mac_row <= '0;
      mac_v0  <= '0;
      mac_v1  <= '0;
    end else begin
      mac_wr <= vld_p1;
      if (vld_p1) begin
        mac_row <= row_p1;
        mac_v0  <= val_p1;
        mac_v1  <= x_p1;
      end
    end
  end

endmodule

// File: tb/tb_mac_feeder.sv
// tb_mac_feeder
//   Directed, table-driven bench for mac_feeder. A vector table holds each
//   nonzero with its expected mac_row and x[col]; a negedge monitor logs
//   accepts, mac beats and eof pulses with cycle stamps for later comparison.
module tb_mac_feeder;
  import mac_feeder_pkg::*;

  localparam int XD  = 1024;
  localparam int ID  = 8;
  localparam int GAP = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        x_wr;
  logic [9:0]  x_addr;
  logic [63:0] x_data;
  logic        nz_valid;
  logic        nz_ready;
  logic [31:0] nz_row;
  logic [31:0] nz_col;
  logic [63:0] nz_val;
  logic        nz_last;
  logic        mac_wr;
  logic [2:0]  mac_row;
  logic [63:0] mac_v0;
  logic [63:0] mac_v1;
  logic        mac_eof;
  logic        busy;
  logic        done;
  logic [2:0]  err;
  logic [31:0] nnz_count;

  always #5 clk = ~clk;

  mac_feeder #(
    .INTERMEDIATOR_DEPTH (ID),
    .X_DEPTH             (XD),
    .EOF_GAP             (GAP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .x_wr      (x_wr),
    .x_addr    (x_addr),
    .x_data    (x_data),
    .nz_valid  (nz_valid),
    .nz_ready  (nz_ready),
    .nz_row    (nz_row),
    .nz_col    (nz_col),
    .nz_val    (nz_val),
    .nz_last   (nz_last),
    .mac_wr    (mac_wr),
    .mac_row   (mac_row),
    .mac_v0    (mac_v0),
    .mac_v1    (mac_v1),
    .mac_eof   (mac_eof),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .nnz_count (nnz_count)
  );

  typedef struct {
    logic [31:0] row;
    logic [31:0] col;
    logic [63:0] val;
    logic        last;
    logic [2:0]  exp_row;
    logic [63:0] exp_v1;
  } vec_t;

  vec_t vecs [19];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int done_bad = 0;

  int          acc_q[$];
  int          wr_q[$];
  int          eof_q[$];
  logic [2:0]  row_q[$];
  logic [63:0] v0_q[$];
  logic [63:0] v1_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // cyc at a negedge equals the number of posedges so far: an accept seen
  // here happens at edge cyc+1, a beat seen here was launched by edge cyc.
  always @(negedge clk) begin
    if (!rst) begin
      if (nz_valid && nz_ready) acc_q.push_back(cyc + 1);
      if (mac_wr) begin
        wr_q.push_back(cyc);
        row_q.push_back(mac_row);
        v0_q.push_back(mac_v0);
        v1_q.push_back(mac_v1);
      end
      if (mac_eof) eof_q.push_back(cyc);
      if (done !== mac_eof) done_bad++;
    end
  end

  function automatic vec_t mk(input logic [31:0] r, input logic [31:0] c, input real v,
                              input logic l, input logic [2:0] er, input real xv);
    vec_t t;
    t.row = r; t.col = c; t.val = $realtobits(v); t.last = l;
    t.exp_row = er; t.exp_v1 = $realtobits(xv);
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    acc_q.delete(); wr_q.delete(); eof_q.delete();
    row_q.delete(); v0_q.delete(); v1_q.delete();
  endtask

  task automatic xwrite(input int a, input real v);
    x_wr = 1'b1; x_addr = 10'(a); x_data = $realtobits(v);
    tick();
    x_wr = 1'b0;
  endtask

  task automatic start_run();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input int i);
    int w = 0;
    nz_valid = 1'b1;
    nz_row = vecs[i].row; nz_col = vecs[i].col;
    nz_val = vecs[i].val; nz_last = vecs[i].last;
    while (!nz_ready && w < 20) begin tick(); w++; end
    chk("ready_wait", {63'd0, nz_ready}, 64'd1);
    tick();
  endtask

  task automatic run_vecs(input int first, input int n, input bit toggle);
    for (int k = 0; k < n; k++) begin
      send(first + k);
      if (toggle) begin nz_valid = 1'b0; tick(); end
    end
    nz_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int w = 0;
    while (busy && w < 200) begin @(negedge clk); w++; end
    chk("idle_timeout", {63'd0, busy}, 64'd0);
  endtask

  task automatic verify_vecs(input string name, input int first, input int n);
    chk({name, "_beats"}, 64'(wr_q.size()), 64'(n));
    for (int k = 0; k < n && k < wr_q.size() && k < acc_q.size(); k++) begin
      chk($sformatf("%s_row%0d", name, k), {61'd0, row_q[k]}, {61'd0, vecs[first+k].exp_row});
      chk($sformatf("%s_v0_%0d", name, k), v0_q[k], vecs[first+k].val);
      chk($sformatf("%s_v1_%0d", name, k), v1_q[k], vecs[first+k].exp_v1);
      chk($sformatf("%s_lat%0d", name, k), 64'(wr_q[k] - acc_q[k]), 64'd2);
    end
  endtask

  initial begin
    int w;
    rst = 1'b1; start = 1'b0; x_wr = 1'b0; x_addr = '0; x_data = '0;
    nz_valid = 1'b0; nz_row = '0; nz_col = '0; nz_val = '0; nz_last = 1'b0;

    vecs[0] = mk(0, 3, 0.5,  1'b0, 3'd0, 4.0);
    vecs[1] = mk(0, 1, 2.0,  1'b0, 3'd0, 2.0);
    vecs[2] = mk(1, 0, -1.0, 1'b0, 3'd1, 1.0);
    vecs[3] = mk(5, 2, 1.5,  1'b1, 3'd5, 3.0);
    vecs[4] = mk(3, 0, 1.0,  1'b0, 3'd3, 1.0);
    vecs[5] = mk(2, 1, 2.0,  1'b1, 3'd2, 2.0);
    vecs[6] = mk(7, 2000, 0.5, 1'b1, 3'd7, 8.0);
    vecs[7] = mk(9, 0, 1.5,  1'b1, 3'd1, 1.0);
    for (int k = 0; k < 10; k++)
      vecs[8+k] = mk(k, k % 4, real'(k + 1), k == 9, 3'(k % 8), real'(k % 4 + 1));
    vecs[18] = mk(4, 1, 2.0, 1'b1, 3'd4, 2.0);

    repeat (2) tick();
    chk("rst_nz_ready", {63'd0, nz_ready}, 64'd0);
    chk("rst_mac_wr",   {63'd0, mac_wr},   64'd0);
    chk("rst_mac_eof",  {63'd0, mac_eof},  64'd0);
    chk("rst_busy",     {63'd0, busy},     64'd0);
    chk("rst_done",     {63'd0, done},     64'd0);
    chk("rst_err",      {61'd0, err},      64'd0);
    chk("rst_nnz",      {32'd0, nnz_count}, 64'd0);
    chk("rst_v0",       mac_v0, 64'd0);
    rst = 1'b0;
    tick();

    xwrite(0, 1.0); xwrite(1, 2.0); xwrite(2, 3.0); xwrite(3, 4.0);
    xwrite(976, 8.0);

    // Basic stream, latency, eof gap
    clear_q();
    start_run();
    chk("t1_busy", {63'd0, busy}, 64'd1);
    chk("t1_ready", {63'd0, nz_ready}, 64'd1);
    run_vecs(0, 4, 1'b0);
    chk("t1_ready_low", {63'd0, nz_ready}, 64'd0);
    w = 0;
    while (!mac_eof && w < 100) begin @(negedge clk); w++; end
    chk("t1_eof_seen", {63'd0, mac_eof}, 64'd1);
    chk("t1_done", {63'd0, done}, 64'd1);
    chk("t1_busy_at_eof", {63'd0, busy}, 64'd1);
    if (wr_q.size() > 0 && eof_q.size() > 0)
      chk("t1_eof_gap", 64'(eof_q[0] - wr_q[wr_q.size()-1]), 64'(GAP));
    @(negedge clk);
    chk("t1_busy_after", {63'd0, busy}, 64'd0);
    chk("t1_eof_pulse", {63'd0, mac_eof}, 64'd0);
    chk("t1_eof_count", 64'(eof_q.size()), 64'd1);
    verify_vecs("t1", 0, 4);
    if (wr_q.size() == 4)
      chk("t1_consec", 64'(wr_q[3] - wr_q[0]), 64'd3);
    chk("t1_nnz", {32'd0, nnz_count}, 64'd4);
    chk("t1_err", {61'd0, err}, 64'd0);
    chk("t1_hold_v0", mac_v0, $realtobits(1.5));
    chk("t1_hold_row", {61'd0, mac_row}, 64'd5);

    // Row order violation, then cleared by the next start
    clear_q();
    start_run();
    run_vecs(4, 2, 1'b0);
    wait_idle();
    verify_vecs("t2", 4, 2);
    chk("t2_err", {61'd0, err}, 64'd1);
    start_run();
    chk("t2_err_clr", {61'd0, err}, 64'd0);
    chk("t2_nnz_clr", {32'd0, nnz_count}, 64'd0);
    run_vecs(3, 1, 1'b0);
    wait_idle();

    // x_wr while busy and column out of range
    clear_q();
    start_run();
    x_wr = 1'b1; x_addr = 10'd0; x_data = 64'hDEAD_BEEF_0000_0001;
    send(6);
    x_wr = 1'b0; nz_valid = 1'b0;
    wait_idle();
    verify_vecs("t3", 6, 1);
    chk("t3_err", {61'd0, err}, 64'd6);
    clear_q();
    start_run();
    run_vecs(7, 1, 1'b0);
    wait_idle();
    verify_vecs("t3b", 7, 1);
    chk("t3b_err", {61'd0, err}, 64'd0);

    // nz_valid toggling every other cycle
    clear_q();
    start_run();
    run_vecs(8, 10, 1'b1);
    wait_idle();
    verify_vecs("t4", 8, 10);
    chk("t4_nnz", {32'd0, nnz_count}, 64'd10);

    // Reset in the middle of a stream
    clear_q();
    start_run();
    send(0); send(1); send(2);
    chk("t5_pre_wr", {63'd0, mac_wr}, 64'd1);
    rst = 1'b1;
    #1;
    chk("t5_nz_ready", {63'd0, nz_ready}, 64'd0);
    chk("t5_mac_wr",   {63'd0, mac_wr},   64'd0);
    chk("t5_busy",     {63'd0, busy},     64'd0);
    chk("t5_nnz",      {32'd0, nnz_count}, 64'd0);
    chk("t5_v0",       mac_v0, 64'd0);
    chk("t5_v1",       mac_v1, 64'd0);
    chk("t5_row",      {61'd0, mac_row}, 64'd0);
    chk("t5_eof",      {63'd0, mac_eof}, 64'd0);
    nz_valid = 1'b0;
    tick();
    rst = 1'b0;
    clear_q();
    repeat (30) tick();
    chk("t5_no_eof", 64'(eof_q.size()), 64'd0);
    chk("t5_no_wr",  64'(wr_q.size()),  64'd0);
    xwrite(0, 1.0); xwrite(1, 2.0); xwrite(2, 3.0); xwrite(3, 4.0);
    clear_q();
    start_run();
    run_vecs(18, 1, 1'b0);
    wait_idle();
    verify_vecs("t5b", 18, 1);
    chk("t5b_nnz", {32'd0, nnz_count}, 64'd1);

    chk("done_eq_eof", 64'(done_bad), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
